// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 initiator (MSB first) with optional chip-select hold for bursts.
// All outputs registered; a byte takes 1+17*CLK_DIV cycles from start to rx_valid.
module spi_master #(
  parameter int CLK_DIV = 8,
  parameter int CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       start,
  input  logic       hold_cs,
  input  logic       cs_release,
  output logic       ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       spi_clk,
  output logic       mosi,
  output logic       cs_n,
  input  logic       miso
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] half_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             phase_end;

  assign phase_end = (half_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      ready    <= 1'b1;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          half_cnt <= '0;
          if (start) begin
            tx_sr   <= tx_byte;
            mosi    <= tx_byte[7];
            cs_n    <= 1'b0;
            ready   <= 1'b0;
            bit_cnt <= '0;
            state   <= SETUP;
          end else if (cs_release && !cs_n) begin
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
            ready <= 1'b0;
            state <= GAP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            half_cnt <= '0;
            spi_clk  <= 1'b1;
            state    <= HIGH;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            half_cnt <= '0;
            spi_clk  <= 1'b0;
            rx_sr    <= {rx_sr[6:0], miso};
            bit_cnt  <= bit_cnt + 1'b1;
            // After the 8th sample mosi keeps bit 0 instead of shifting in a zero
            if (bit_cnt != 4'd7) begin
              tx_sr <= {tx_sr[6:0], 1'b0};
              mosi  <= tx_sr[6];
            end
            state <= LOW;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        LOW: begin
          if (phase_end) begin
            half_cnt <= '0;
            if (bit_cnt == 4'd8) begin
              rx_byte  <= rx_sr;
              rx_valid <= 1'b1;
              if (hold_cs) begin
                ready <= 1'b1;
                state <= IDLE;
              end else begin
                cs_n  <= 1'b1;
                mosi  <= 1'b0;
                state <= GAP;
              end
            end else begin
              spi_clk <= 1'b1;
              state   <= HIGH;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            half_cnt <= '0;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=8 instance for most steps, CLK_DIV=2 instance for the fast build.
module tb_spi_master;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset;
  logic [7:0] tx_byte;
  logic       start, hold_cs, cs_release;
  logic       loop_en, miso_val;
  logic       ready, rx_valid, spi_clk, mosi, cs_n, miso;
  logic [7:0] rx_byte;

  logic [7:0] tx_byte2;
  logic       start2, hold_cs2, cs_release2;
  logic       ready2, rx_valid2, spi_clk2, mosi2, cs_n2;
  logic [7:0] rx_byte2;

  assign miso = loop_en ? mosi : miso_val;

  spi_master #(.CLK_DIV(8), .CNT_W(8)) dut (
    .CLK(CLK), .reset(reset), .tx_byte(tx_byte), .start(start), .hold_cs(hold_cs),
    .cs_release(cs_release), .ready(ready), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  spi_master #(.CLK_DIV(2), .CNT_W(8)) dut2 (
    .CLK(CLK), .reset(reset), .tx_byte(tx_byte2), .start(start2), .hold_cs(hold_cs2),
    .cs_release(cs_release2), .ready(ready2), .rx_byte(rx_byte2), .rx_valid(rx_valid2),
    .spi_clk(spi_clk2), .mosi(mosi2), .cs_n(cs_n2), .miso(mosi2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Waveform monitors, sampled mid-cycle
  logic       mon_clr = 1'b0;
  logic       prev_clk = 1'b0, prev_csn = 1'b1, prev_clk2 = 1'b0;
  logic [7:0] mosi_cap = '0;
  int pulses = 0, hi_len = 0, hi_min = 255, hi_max = 0, viol = 0, rxv_cnt = 0, csn_rise = 0;
  int pulses2 = 0, last2 = 0, per_min2 = 1000, per_max2 = 0;
  logic have2 = 1'b0;

  always @(negedge CLK) begin
    prev_clk  <= spi_clk;
    prev_csn  <= cs_n;
    prev_clk2 <= spi_clk2;
    if (mon_clr) begin
      mosi_cap <= '0; pulses <= 0; hi_len <= 0; hi_min <= 255; hi_max <= 0;
      viol <= 0; rxv_cnt <= 0; csn_rise <= 0;
      pulses2 <= 0; per_min2 <= 1000; per_max2 <= 0; have2 <= 1'b0;
    end else begin
      if (spi_clk && !prev_clk) begin
        mosi_cap <= {mosi_cap[6:0], mosi};
        pulses   <= pulses + 1;
      end
      hi_len <= spi_clk ? hi_len + 1 : 0;
      if (!spi_clk && prev_clk) begin
        if (hi_len < hi_min) hi_min <= hi_len;
        if (hi_len > hi_max) hi_max <= hi_len;
      end
      if (spi_clk && cs_n) viol <= viol + 1;
      if (rx_valid) rxv_cnt <= rxv_cnt + 1;
      if (cs_n && !prev_csn) csn_rise <= csn_rise + 1;
      if (spi_clk2 && !prev_clk2) begin
        pulses2 <= pulses2 + 1;
        last2   <= cyc;
        have2   <= 1'b1;
        if (have2) begin
          if (cyc - last2 < per_min2) per_min2 <= cyc - last2;
          if (cyc - last2 > per_max2) per_max2 <= cyc - last2;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge CLK); mon_clr = 1'b1;
    @(posedge CLK); mon_clr = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 60) begin n++; @(negedge CLK); end
  endtask

  initial begin
    int t0, n;
    reset = 1'b1; tx_byte = '0; start = 1'b0; hold_cs = 1'b0; cs_release = 1'b0;
    loop_en = 1'b1; miso_val = 1'b0;
    tx_byte2 = '0; start2 = 1'b0; hold_cs2 = 1'b0; cs_release2 = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("rst_ready", ready, 1);     check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_byte", rx_byte, 0); check("rst_spi_clk", spi_clk, 0);
    check("rst_mosi", mosi, 0);       check("rst_cs_n", cs_n, 1);

    // A: loopback 0xA5
    clear_mon();
    tx_byte = 8'hA5; start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    check("A_ready_low", ready, 0); check("A_cs_low", cs_n, 0); check("A_mosi7", mosi, 1);
    while (!rx_valid && cyc - t0 < 400) @(negedge CLK);
    check("A_latency", cyc - t0, 137);
    check("A_rx_byte", rx_byte, 8'hA5);
    check("A_cs_at_valid", cs_n, 1);
    wait_ready(n);
    check("A_gap_cycles", n, 8);
    check("A_mosi_edges", mosi_cap, 8'hA5);
    check("A_pulses", pulses, 8);
    check("A_rxv_count", rxv_cnt, 1);

    // B: miso tied high, 0x3C
    loop_en = 1'b0; miso_val = 1'b1;
    clear_mon();
    tx_byte = 8'h3C; start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    while (!rx_valid && cyc - t0 < 400) @(negedge CLK);
    check("B_rx_byte", rx_byte, 8'hFF);
    wait_ready(n);
    check("B_pulses", pulses, 8);
    check("B_high_min", hi_min, 8);
    check("B_high_max", hi_max, 8);
    check("B_clk_while_cs_high", viol, 0);
    check("B_mosi_edges", mosi_cap, 8'h3C);

    // C: second start mid-transfer is ignored
    loop_en = 1'b1;
    clear_mon();
    tx_byte = 8'h5A; start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    while (cyc - t0 < 40) @(negedge CLK);
    tx_byte = 8'h00; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    while (!rx_valid && cyc - t0 < 400) @(negedge CLK);
    check("C_latency", cyc - t0, 137);
    check("C_rx_byte", rx_byte, 8'h5A);
    wait_ready(n);
    repeat (200) @(negedge CLK);
    check("C_rxv_count", rxv_cnt, 1);
    check("C_cs_idle", cs_n, 1);
    check("C_rx_held", rx_byte, 8'h5A);

    // D: held-CS burst 0x12, 0x34 then release
    hold_cs = 1'b1;
    clear_mon();
    tx_byte = 8'h12; start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    while (!rx_valid && cyc - t0 < 400) @(negedge CLK);
    check("D1_rx_byte", rx_byte, 8'h12);
    check("D1_ready_with_valid", ready, 1);
    check("D1_cs_held", cs_n, 0);
    tx_byte = 8'h34; start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    check("D2_cs_held_start", cs_n, 0);
    while (!rx_valid && cyc - t0 < 400) @(negedge CLK);
    check("D2_latency", cyc - t0, 137);
    check("D2_rx_byte", rx_byte, 8'h34);
    repeat (5) @(negedge CLK);
    check("D2_cs_still_held", cs_n, 0);
    check("D2_ready", ready, 1);
    hold_cs = 1'b0; cs_release = 1'b1;
    @(negedge CLK); cs_release = 1'b0;
    check("D_release_cs", cs_n, 1);
    check("D_release_busy", ready, 0);
    wait_ready(n);
    check("D_release_gap", n, 8);
    check("D_cs_rises", csn_rise, 1);
    check("D_rxv_count", rxv_cnt, 2);

    // E: reset mid-transfer
    clear_mon();
    tx_byte = 8'hF7; start = 1'b1; t0 = cyc;
    @(negedge CLK); start = 1'b0;
    while (cyc - t0 < 60) @(negedge CLK);
    check("E_pre_spi_clk", spi_clk, 1);
    check("E_pre_mosi", mosi, 1);
    reset = 1'b1;
    @(negedge CLK); reset = 1'b0;
    check("E_cs_n", cs_n, 1);   check("E_spi_clk", spi_clk, 0);
    check("E_mosi", mosi, 0);   check("E_ready", ready, 1);
    check("E_rx_valid", rx_valid, 0);
    repeat (200) @(negedge CLK);
    check("E_no_rxv", rxv_cnt, 0);
    check("E_cs_idle", cs_n, 1);

    // F: CLK_DIV=2 instance, 0xFF looped
    clear_mon();
    tx_byte2 = 8'hFF; start2 = 1'b1; t0 = cyc;
    @(negedge CLK); start2 = 1'b0;
    while (!rx_valid2 && cyc - t0 < 100) @(negedge CLK);
    check("F_latency", cyc - t0, 35);
    check("F_rx_byte", rx_byte2, 8'hFF);
    check("F_per_min", per_min2, 4);
    check("F_per_max", per_max2, 4);
    check("F_pulses", pulses2, 8);
    n = 0;
    while (!ready2 && n < 20) begin n++; @(negedge CLK); end
    check("F_gap_cycles", n, 2);
    check("F_cs_idle", cs_n2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
